muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file. It consumes the two register read operands (ALUop1 and regOp2 values) plus the decoded funct3 and destination register index. It computes one bit per cycle and returns a 32-bit result with a one-cycle done pulse and the destination tag for writeback (RegWrite/WD3 path). The main pipeline stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32, operand/result width (W)
- `ADDRESS_WIDTH`, 5, register index width
- `clk` in 1, rising-edge clock
- `rst` in 1, asynchronous active-high reset
- `start` in 1, request; accepted only when `busy`=0
- `funct3` in 3, op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op1` in W, rs1 value (dividend / multiplicand)
- `op2` in W, rs2 value (divisor / multiplier)
- `rd_in` in ADDRESS_WIDTH, destination index, latched with the request
- `busy` out 1, high while iterating
- `done` out 1, one-cycle pulse; `result`/`rd_out` valid
- `result` out W, registered result
- `rd_out` out ADDRESS_WIDTH, destination index of the completed op

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - CALC: `busy`=1.
  - DONE: `done`=1, `busy`=0, lasts exactly one cycle.
- IDLE or DONE with `start`=1: latch `funct3`, `rd_in`, operand magnitudes and sign flags. Load the iteration counter with 0 and go to CALC.
- DONE with `start`=0 goes to IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Multiply: unsigned shift-add on magnitudes into a 2W-bit product. Negate the product if the operand signs differ.
  - MUL returns product[W-1:0].
  - MULH, MULHSU and MULHU return product[2W-1:W].
- Divide: restoring division on magnitudes, one quotient bit per cycle. Quotient sign = sign1 XOR sign2. Remainder sign = sign1.
- Divide by zero (op2==0):
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return op1 unchanged.
- Signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- CALC ignores `start`, `funct3`, `op1`, `op2` and `rd_in`. A start while `busy`=1 is dropped, not queued.
- `result` and `rd_out` hold until the next completion overwrites them.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0. Reset applies immediately, independent of `clk`.
- Reset mid-CALC abandons the op: no `done` pulse, and `result` becomes 0.
- Accept edge E0 (`start`=1, `busy`=0). CALC performs one iteration per edge, at E1..EW.
- Edge EW loads the sign-corrected `result` and enters DONE. `done` is high in the cycle after EW.
- Latency = W edges (32 by default). Throughput is one op per W edges: a start during DONE is accepted back-to-back.
- `busy` is high in the cycles after E0..E(W-1).

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: the fast path below applies.
  - Fast-path conditions: a divide op with op2==0, or a multiply op with op1==0 or op2==0.
  - On such a start, go from E0 directly to DONE with the special/zero result loaded. `done` is high in the cycle after E0 (latency 1) and `busy` never rises.
  - Signed overflow still iterates.
- Macro absent: every op takes W edges. Results are bit-identical in both builds.

## Test plan
- MUL, op1=7, op2=0xFFFFFFFD -> `result`=0xFFFFFFEB, `rd_out`=`rd_in`. `done` pulses for exactly one cycle after the 32nd edge from acceptance; `busy` is high 32 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM for the same operands -> 0.
- Back-to-back and reset:
  - Start asserted during DONE -> second op accepted, both results correct.
  - Start pulsed at cycle 10 of CALC -> ignored.
  - `rst` at cycle 10 of CALC -> `busy`=0 and `result`=0 immediately, no `done` pulse.
- DIVU 9/0 -> 0xFFFFFFFF. With `MULDIV_EARLY_OUT_EN`: `done` after 1 edge and `busy` stays 0. Without it: `done` after 32 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN finishes zero-operand multiplies and divide-by-zero in one edge.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op1,
    input  logic [DATA_WIDTH-1:0]    op2,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [2:0]               r_op;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic [W-1:0]             r_m;
    logic [2*W-1:0]           r_acc;
    logic                     r_s1;
    logic                     r_s2;
    logic                     r_dz;
    logic [CW-1:0]            r_cnt;

    logic                     w_accept;
    logic                     w_sgn1;
    logic                     w_sgn2;
    logic                     w_neg1;
    logic                     w_neg2;
    logic [W-1:0]             w_mag1;
    logic [W-1:0]             w_mag2;
    logic [W:0]               w_add;
    logic [W:0]               w_shrem;
    logic [W:0]               w_trial;
    logic [2*W-1:0]           w_iter;
    logic [2*W-1:0]           w_prod;
    logic [W-1:0]             w_final;
    logic                     w_fast;
    logic [W-1:0]             w_fast_result;

    assign w_accept = start && (r_state != S_CALC);

    always_comb begin
        w_sgn1 = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        w_sgn2 = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
        w_neg1 = w_sgn1 && op1[W-1];
        w_neg2 = w_sgn2 && op2[W-1];
        w_mag1 = w_neg1 ? (~op1 + {{(W-1){1'b0}}, 1'b1}) : op1;
        w_mag2 = w_neg2 ? (~op2 + {{(W-1){1'b0}}, 1'b1}) : op2;
    end

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        w_add   = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_m : {W{1'b0}})};
        w_shrem = {r_acc[2*W-1:W], r_acc[W-1]};
        w_trial = w_shrem - {1'b0, r_m};
        if (r_op[2]) begin
            if (w_shrem >= {1'b0, r_m}) begin
                w_iter = {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
            end else begin
                w_iter = {w_shrem[W-1:0], r_acc[W-2:0], 1'b0};
            end
        end else begin
            w_iter = {w_add, r_acc[W-1:1]};
        end
    end

    always_comb begin
        w_prod = (r_s1 ^ r_s2) ? (~w_iter + {{(2*W-1){1'b0}}, 1'b1}) : w_iter;
        case (r_op)
            3'b000:                 w_final = w_prod[W-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*W-1:W];
            3'b100, 3'b101: begin
                if (r_dz) begin
                    w_final = {W{1'b1}};
                end else if (r_s1 ^ r_s2) begin
                    w_final = ~w_iter[W-1:0] + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    w_final = w_iter[W-1:0];
                end
            end
            3'b110, 3'b111: begin
                if (r_s1) begin
                    w_final = ~w_iter[2*W-1:W] + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    w_final = w_iter[2*W-1:W];
                end
            end
            default:                w_final = {W{1'b0}};
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        if (funct3[2]) begin
            w_fast        = (op2 == {W{1'b0}});
            w_fast_result = funct3[1] ? op1 : {W{1'b1}};
        end else begin
            w_fast        = (op1 == {W{1'b0}}) || (op2 == {W{1'b0}});
            w_fast_result = {W{1'b0}};
        end
    end
`else
    assign w_fast        = 1'b0;
    assign w_fast_result = {W{1'b0}};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = w_fast ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CALC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_state)
            S_CALC:  begin busy = 1'b1; done = 1'b0; end
            S_DONE:  begin busy = 1'b0; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= 3'b000;
            r_rd   <= {ADDRESS_WIDTH{1'b0}};
            r_m    <= {W{1'b0}};
            r_acc  <= {(2*W){1'b0}};
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            result <= {W{1'b0}};
            rd_out <= {ADDRESS_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_op  <= funct3;
            r_rd  <= rd_in;
            r_s1  <= w_neg1;
            r_s2  <= w_neg2;
            r_dz  <= (op2 == {W{1'b0}});
            r_cnt <= {CW{1'b0}};
            r_m   <= funct3[2] ? w_mag2 : w_mag1;
            r_acc <= {{W{1'b0}}, (funct3[2] ? w_mag1 : w_mag2)};
            if (w_fast) begin
                result <= w_fast_result;
                rd_out <= rd_in;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_iter;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == LAST) begin
                result <= w_final;
                rd_out <= r_rd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op1(op1), .op2(op2), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea;
        logic [63:0]        eb;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (f3 == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
        eb  = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = ea * eb;
        case (f3)
            3'b000:  return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100:  return (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'b101:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 32'h0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2] ? (b == 32'h0) : (a == 32'h0 || b == 32'h0)) return 0;
`endif
        return 32;
    endfunction

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        funct3 = f3;
        op1    = a;
        op2    = b;
        rd_in  = rd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Counts edges after acceptance until done, bounded so a stuck DUT still ends the run.
    task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd, input int lat_exp);
        int lat;
        int nb;
        lat = 0;
        nb  = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nb++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(lat_exp));
        check({tag, ".busycyc"}, 32'(nb), 32'(lat_exp));
        check({tag, ".res"}, result, exp_res);
        check({tag, ".rd"}, {27'd0, rd_out}, {27'd0, exp_rd});
        check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        @(negedge clk);
        launch(f3, a, b, rd);
        finish_op(tag, exp_res, rd, exp_lat(f3, a, b));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        int          ndone;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        op1    = 32'h0;
        op2    = 32'h0;
        rd_in  = 5'd0;
        #3;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_one("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        run_one("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000);
        run_one("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
        run_one("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
        run_one("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD);
        run_one("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF);
        run_one("divu",   3'b101, 32'd100,        32'd7,         5'd9,  32'd14);
        run_one("remu",   3'b111, 32'd100,        32'd7,         5'd10, 32'd2);
        run_one("div0",   3'b100, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF);
        run_one("rem0",   3'b110, 32'd5,          32'd0,         5'd12, 32'd5);
        run_one("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_one("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0);
        run_one("divu0",  3'b101, 32'd9,          32'd0,         5'd15, 32'hFFFF_FFFF);
        run_one("mulz",   3'b000, 32'd0,          32'd1234,      5'd16, 32'd0);

        // Second start while in DONE is accepted with no idle gap.
        @(negedge clk);
        launch(3'b101, 32'd1000, 32'd3, 5'd17);
        finish_op("b2b.a", 32'd333, 5'd17, 32);
        launch(3'b000, 32'hFFFF_FFFE, 32'd21, 5'd18);
        finish_op("b2b.b", 32'hFFFF_FFD6, 5'd18, 32);

        // Start pulsed mid-iteration is dropped.
        @(negedge clk);
        launch(3'b111, 32'd1000, 32'd7, 5'd19);
        lat = 0;
        repeat (10) begin @(posedge clk); #1; lat++; end
        funct3 = 3'b000;
        op1    = 32'd3;
        op2    = 32'd3;
        rd_in  = 5'd1;
        start  = 1'b1;
        @(posedge clk); #1; lat++;
        start  = 1'b0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("ign.lat", 32'(lat), 32'd32);
        check("ign.res", result, 32'd6);
        check("ign.rd", {27'd0, rd_out}, 32'd19);
        @(posedge clk); #1;
        check("ign.noqueue.busy", {31'd0, busy}, 32'd0);
        check("ign.noqueue.done", {31'd0, done}, 32'd0);

        // Reset mid-iteration abandons the op.
        @(negedge clk);
        launch(3'b101, 32'd5000, 32'd9, 5'd20);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.busy", {31'd0, busy}, 32'd0);
        check("rstmid.result", result, 32'd0);
        check("rstmid.done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) ndone++; end
        check("rstmid.nodone", 32'(ndone), 32'd0);

        for (int i = 0; i < 200; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            run_one($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), f, a, b, rd, ref_model(f, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
